la_status_checker: RTL

Synthesizable status-code sequence checker in the user project area. It watches the 16-bit status word and 8-bit test ID that firmware drives onto the LA/GPIO status field, and enforces the per-test phase order START → READ → PROC → WRITE → DONE/FAIL, repeated until ALLDONE. It counts passes, fails and protocol errors, and runs a programmable inactivity watchdog. Software reads the counters over Wishbone/LA, so a hardware verdict exists without a testbench monitor.

---
 rtl/la_status_checker.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/la_status_checker.sv
// Status-code sequence checker: enforces START/READ/PROC/WRITE/result ordering per test ID,
// counts passes, fails and protocol errors, and runs an inactivity watchdog.
module la_status_checker #(
    parameter int unsigned       CODE_W = 16,
    parameter logic [CODE_W-9:0] PREFIX = 8'hAB,
    parameter int unsigned       ID_W   = 8,
    parameter int unsigned       CNT_W  = 8,
    parameter int unsigned       TO_W   = 20
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              clear_i,
    input  logic [CODE_W-1:0] code_i,
    input  logic [ID_W-1:0]   id_i,
    input  logic [TO_W-1:0]   timeout_cycles_i,
    output logic [2:0]        state_o,
    output logic [ID_W-1:0]   cur_id_o,
    output logic [CNT_W-1:0]  pass_cnt_o,
    output logic [CNT_W-1:0]  fail_cnt_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic              event_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StStarted = 3'd1,
        StRead    = 3'd2,
        StProc    = 3'd3,
        StWrite   = 3'd4,
        StResult  = 3'd5,
        StDone    = 3'd6,
        StTimeout = 3'd7
    } state_e;

    localparam logic [7:0] PhStart   = 8'h40;
    localparam logic [7:0] PhRead    = 8'h41;
    localparam logic [7:0] PhProc    = 8'h42;
    localparam logic [7:0] PhWrite   = 8'h51;
    localparam logic [7:0] PhWDone   = 8'h43;
    localparam logic [7:0] PhWFail   = 8'h44;
    localparam logic [7:0] PhAllDone = 8'hFF;

    state_e            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_prev_q;
    logic [ID_W-1:0]   id_q, cur_id_q;
    logic [CNT_W-1:0]  pass_q, fail_q, err_cnt_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic              event_q, err_q, done_q, timeout_q;

    logic [7:0] phase;
    logic       evt, legal, id_ok, to_last;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign phase   = code_q[7:0];
    assign evt     = (code_q != code_prev_q) && (code_q[CODE_W-1:8] == PREFIX);
    assign id_ok   = (phase == PhStart) || (id_q == cur_id_q);
    assign to_last = (timeout_cycles_i != '0) && (to_cnt_q == timeout_cycles_i - TO_W'(1));

    // Legal phase transitions; anything not listed here is a protocol error.
    always_comb begin
        legal   = 1'b0;
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (phase == PhStart) begin
                    legal   = 1'b1;
                    state_d = StStarted;
                end else if (phase == PhAllDone) begin
                    legal   = 1'b1;
                    state_d = StDone;
                end
            end
            StStarted: if (phase == PhRead) begin
                legal   = 1'b1;
                state_d = StRead;
            end
            StRead: if (phase == PhProc) begin
                legal   = 1'b1;
                state_d = StProc;
            end
            StProc: if (phase == PhWrite) begin
                legal   = 1'b1;
                state_d = StWrite;
            end
            StWrite: if (phase == PhWDone || phase == PhWFail) begin
                legal   = 1'b1;
                state_d = StResult;
            end
            StResult: begin
                if (phase == PhStart) begin
                    legal   = 1'b1;
                    state_d = StStarted;
                end else if (phase == PhAllDone) begin
                    legal   = 1'b1;
                    state_d = StDone;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            code_q      <= '0;
            id_q        <= '0;
            code_prev_q <= '0;
            state_q     <= StIdle;
            cur_id_q    <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
            err_cnt_q   <= '0;
            to_cnt_q    <= '0;
            event_q     <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else if (clear_i) begin
            // Keep capturing so a code held across the clear is not re-detected.
            code_q      <= code_i;
            id_q        <= id_i;
            code_prev_q <= code_q;
            state_q     <= StIdle;
            cur_id_q    <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
            err_cnt_q   <= '0;
            to_cnt_q    <= '0;
            event_q     <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            code_q      <= code_i;
            id_q        <= id_i;
            code_prev_q <= code_q;
            event_q     <= 1'b0;
            err_q       <= 1'b0;
            if (state_q == StDone || state_q == StTimeout) begin
                to_cnt_q <= '0;
            end else if (evt) begin
                to_cnt_q <= '0;
                if (legal && id_ok) begin
                    state_q <= state_d;
                    event_q <= 1'b1;
                    if (phase == PhStart) cur_id_q <= id_q;
                    if (state_q == StWrite && phase == PhWDone) pass_q <= sat_inc(pass_q);
                    if (state_q == StWrite && phase == PhWFail) fail_q <= sat_inc(fail_q);
                    if (state_d == StDone) done_q <= 1'b1;
                end else begin
                    err_q     <= 1'b1;
                    err_cnt_q <= sat_inc(err_cnt_q);
                end
            end else if (state_q == StIdle) begin
                to_cnt_q <= '0;
            end else if (to_last) begin
                state_q   <= StTimeout;
                timeout_q <= 1'b1;
                to_cnt_q  <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end
        end
    end

    assign state_o    = state_q;
    assign cur_id_o   = cur_id_q;
    assign pass_cnt_o = pass_q;
    assign fail_cnt_o = fail_q;
    assign err_cnt_o  = err_cnt_q;
    assign done_o     = done_q;
    assign timeout_o  = timeout_q;
    assign event_o    = event_q;
    assign err_o      = err_q;

endmodule
